// File: rtl/pipe_sink_stage_if.sv
// pipe_sink_stage_if: valid/allow handshake between an upstream stage and the sink
interface pipe_sink_stage_if #(parameter int DW = 32);
    logic          validin;
    logic [DW-1:0] datain;
    logic          out_allow;
    modport master (output validin, output datain, input out_allow);
    modport slave (input validin, input datain, output out_allow);
endinterface

// File: rtl/pipe_sink_stage.sv
// pipe_sink_stage: pattern-throttled traffic sink with beat count, checksum and sequence check
module pipe_sink_stage #(
    parameter int DW = 32,
    parameter int PW = 8,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    pipe_sink_stage_if.slave up,
    input  logic          enable,
    input  logic          cfg_load,
    input  logic [PW-1:0] cfg_pattern,
    input  logic [DW-1:0] cfg_step,
    input  logic [CW-1:0] cfg_limit,
    output logic [CW-1:0] beat_count,
    output logic [DW-1:0] checksum,
    output logic [DW-1:0] last_data,
    output logic          seq_err,
    output logic          done
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t        state_q, state_d;
    logic [PW-1:0] pat_q, pat_d, cfg_pat_q, cfg_pat_d;
    logic [DW-1:0] step_q, step_d, sum_q, sum_d, last_q, last_d, exp_q, exp_d;
    logic [CW-1:0] lim_q, lim_d, cnt_q, cnt_d;
    logic          err_q, err_d, first_q, first_d, xfer;
    assign up.out_allow = (state_q == RUN) & pat_q[0];
    assign xfer = up.validin & up.out_allow;
    assign beat_count = cnt_q;
    assign checksum = sum_q;
    assign last_data = last_q;
    assign seq_err = err_q;
    assign done = state_q == DONE;
    always_comb begin
        state_d = state_q;
        pat_d = pat_q;
        cfg_pat_d = cfg_pat_q;
        step_d = step_q;
        lim_d = lim_q;
        cnt_d = cnt_q;
        sum_d = sum_q;
        last_d = last_q;
        exp_d = exp_q;
        err_d = err_q;
        first_d = first_q;
        if (state_q == IDLE) begin
            if (cfg_load) begin
                cfg_pat_d = (cfg_pattern == '0) ? '1 : cfg_pattern;
                step_d = cfg_step;
                lim_d = cfg_limit;
            end
            if (enable) begin
                state_d = RUN;
                pat_d = cfg_pat_d;
                cnt_d = '0;
                sum_d = '0;
                last_d = '0;
                err_d = 1'b0;
                first_d = 1'b1;
            end
        end else if (state_q == RUN) begin
            pat_d = {pat_q[0], pat_q[PW-1:1]};
            if (xfer) begin
                cnt_d = cnt_q + CW'(1);
                sum_d = {sum_q[DW-2:0], sum_q[DW-1]} ^ up.datain;
                last_d = up.datain;
                exp_d = up.datain + step_q;
                first_d = 1'b0;
                err_d = err_q | (!first_q && up.datain != exp_q);
            end
            state_d = !enable ? IDLE : (xfer && lim_q != '0 && cnt_d == lim_q) ? DONE : RUN;
        end else begin
            state_d = enable ? DONE : IDLE;
        end
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            pat_q <= '1;
            cfg_pat_q <= '1;
            step_q <= DW'(1);
            lim_q <= '0;
            cnt_q <= '0;
            sum_q <= '0;
            last_q <= '0;
            exp_q <= '0;
            err_q <= 1'b0;
            first_q <= 1'b1;
        end else begin
            state_q <= state_d;
            pat_q <= pat_d;
            cfg_pat_q <= cfg_pat_d;
            step_q <= step_d;
            lim_q <= lim_d;
            cnt_q <= cnt_d;
            sum_q <= sum_d;
            last_q <= last_d;
            exp_q <= exp_d;
            err_q <= err_d;
            first_q <= first_d;
        end
    end
endmodule

// File: tb/tb_pipe_sink_stage.sv
// tb_pipe_sink_stage: directed scenario tests for pipe_sink_stage
module tb_pipe_sink_stage;
    logic        clk = 0;
    logic        rst_n;
    logic        enable, cfg_load;
    logic [7:0]  cfg_pattern;
    logic [31:0] cfg_step;
    logic [15:0] cfg_limit;
    logic [15:0] beat_count;
    logic [31:0] checksum, last_data;
    logic        seq_err, done;
    int checks = 0;
    int failures = 0;
    pipe_sink_stage_if #(.DW(32)) bus ();
    pipe_sink_stage dut (
        .clk(clk), .rst_n(rst_n), .up(bus), .enable(enable), .cfg_load(cfg_load),
        .cfg_pattern(cfg_pattern), .cfg_step(cfg_step), .cfg_limit(cfg_limit),
        .beat_count(beat_count), .checksum(checksum), .last_data(last_data),
        .seq_err(seq_err), .done(done)
    );
    always #5 clk = ~clk;
    task automatic start(input logic [7:0] p, input logic [31:0] s, input logic [15:0] l);
        cfg_pattern = p; cfg_step = s; cfg_limit = l; cfg_load = 1; enable = 1;
        @(negedge clk);
        cfg_load = 0;
    endtask
    task automatic stop();
        enable = 0; bus.validin = 0;
        @(negedge clk);
    endtask
    task automatic test_reset();
        rst_n = 0; enable = 0; cfg_load = 0; bus.validin = 0; bus.datain = 0;
        cfg_pattern = 0; cfg_step = 0; cfg_limit = 0;
        repeat (2) @(negedge clk);
        checks++; if (bus.out_allow !== 1'b0) begin failures++; $display("FAIL reset_allow got=%0h exp=0", bus.out_allow); end
        checks++; if (beat_count !== 16'd0) begin failures++; $display("FAIL reset_count got=%0h exp=0", beat_count); end
        checks++; if (checksum !== 32'd0 || last_data !== 32'd0) begin failures++; $display("FAIL reset_data got=%0h/%0h exp=0/0", checksum, last_data); end
        checks++; if (seq_err !== 1'b0 || done !== 1'b0) begin failures++; $display("FAIL reset_flags got=%0b%0b exp=00", seq_err, done); end
        rst_n = 1;
        @(negedge clk);
    endtask
    task automatic test_back_to_back();
        start(8'hFF, 32'd4, 16'd3);
        bus.validin = 1;
        for (int i = 1; i <= 3; i++) begin
            bus.datain = 32'(4 * i);
            checks++; if (bus.out_allow !== 1'b1) begin failures++; $display("FAIL b2b_allow%0d got=%0h exp=1", i, bus.out_allow); end
            @(negedge clk);
            checks++; if (beat_count !== 16'(i)) begin failures++; $display("FAIL b2b_count%0d got=%0d exp=%0d", i, beat_count, i); end
        end
        checks++; if (done !== 1'b1) begin failures++; $display("FAIL b2b_done got=%0b exp=1", done); end
        checks++; if (last_data !== 32'd12 || seq_err !== 1'b0) begin failures++; $display("FAIL b2b_last got=%0h/%0b exp=c/0", last_data, seq_err); end
        bus.datain = 32'd16;
        for (int i = 0; i < 2; i++) begin
            checks++; if (bus.out_allow !== 1'b0) begin failures++; $display("FAIL b2b_hold_allow got=%0h exp=0", bus.out_allow); end
            @(negedge clk);
        end
        checks++; if (beat_count !== 16'd3 || done !== 1'b1) begin failures++; $display("FAIL b2b_hold got=%0d/%0b exp=3/1", beat_count, done); end
        stop();
        checks++; if (done !== 1'b0 || beat_count !== 16'd3) begin failures++; $display("FAIL b2b_idle got=%0b/%0d exp=0/3", done, beat_count); end
    endtask
    task automatic test_stall();
        logic [7:0] pat;
        logic [31:0] d;
        int n;
        pat = 8'b0000_0101; d = 32'd100; n = 0;
        start(pat, 32'd1, 16'd0);
        bus.validin = 1;
        for (int i = 0; i < 16; i++) begin
            bus.datain = d;
            checks++; if (bus.out_allow !== pat[i % 8]) begin failures++; $display("FAIL stall_allow%0d got=%0h exp=%0h", i, bus.out_allow, pat[i % 8]); end
            @(negedge clk);
            if (pat[i % 8]) begin n++; d++; end
            checks++; if (beat_count !== 16'(n) || last_data !== d - 1) begin failures++; $display("FAIL stall_count%0d got=%0d/%0h exp=%0d/%0h", i, beat_count, last_data, n, d - 1); end
        end
        checks++; if (seq_err !== 1'b0) begin failures++; $display("FAIL stall_seq got=%0b exp=0", seq_err); end
        stop();
    endtask
    task automatic test_seq();
        logic [31:0] data [4];
        logic        err [4];
        data = '{32'd4, 32'd8, 32'd18, 32'd22};
        err = '{1'b0, 1'b0, 1'b1, 1'b1};
        start(8'hFF, 32'd4, 16'd0);
        bus.validin = 1;
        for (int i = 0; i < 4; i++) begin
            bus.datain = data[i];
            if (i == 3) enable = 0;
            @(negedge clk);
            checks++; if (seq_err !== err[i]) begin failures++; $display("FAIL seq_err%0d got=%0b exp=%0b", i, seq_err, err[i]); end
        end
        checks++; if (beat_count !== 16'd4 || bus.out_allow !== 1'b0) begin failures++; $display("FAIL seq_exit got=%0d/%0h exp=4/0", beat_count, bus.out_allow); end
        stop();
    endtask
    task automatic test_checksum();
        start(8'hFF, 32'd1, 16'd0);
        bus.validin = 1; bus.datain = 32'h1;
        @(negedge clk);
        checks++; if (checksum !== 32'h1) begin failures++; $display("FAIL csum1 got=%0h exp=1", checksum); end
        bus.datain = 32'h8000_0000;
        @(negedge clk);
        checks++; if (checksum !== 32'h8000_0002 || last_data !== 32'h8000_0000) begin failures++; $display("FAIL csum2 got=%0h/%0h exp=80000002/80000000", checksum, last_data); end
        stop();
    endtask
    task automatic test_cfg();
        cfg_pattern = 8'h00; cfg_step = 32'd1; cfg_limit = 16'd0; cfg_load = 1;
        @(negedge clk);
        cfg_load = 0; enable = 1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            checks++; if (bus.out_allow !== 1'b1) begin failures++; $display("FAIL cfg_zero_allow%0d got=%0h exp=1", i, bus.out_allow); end
            if (i == 2) begin cfg_pattern = 8'h01; cfg_limit = 16'd1; cfg_load = 1; end
            @(negedge clk);
            cfg_load = 0;
        end
        bus.validin = 1;
        for (int i = 0; i < 3; i++) begin
            bus.datain = 32'(i);
            @(negedge clk);
        end
        checks++; if (beat_count !== 16'd3 || done !== 1'b0 || bus.out_allow !== 1'b1) begin failures++; $display("FAIL cfg_run_load got=%0d/%0b/%0h exp=3/0/1", beat_count, done, bus.out_allow); end
        stop();
    endtask
    task automatic test_reset_midrun();
        start(8'h03, 32'd1, 16'd0);
        bus.validin = 1; bus.datain = 32'd5;
        @(negedge clk);
        bus.datain = 32'd9;
        @(negedge clk);
        checks++; if (beat_count !== 16'd2 || seq_err !== 1'b1) begin failures++; $display("FAIL mid_pre got=%0d/%0b exp=2/1", beat_count, seq_err); end
        rst_n = 0; enable = 0; bus.validin = 0;
        @(negedge clk);
        rst_n = 1;
        checks++; if (bus.out_allow !== 1'b0 || beat_count !== 16'd0 || seq_err !== 1'b0 || checksum !== 32'd0) begin failures++; $display("FAIL mid_reset got=%0h/%0d/%0b/%0h exp=0/0/0/0", bus.out_allow, beat_count, seq_err, checksum); end
        enable = 1;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            checks++; if (bus.out_allow !== 1'b1) begin failures++; $display("FAIL mid_pattern%0d got=%0h exp=1", i, bus.out_allow); end
            @(negedge clk);
        end
        stop();
    endtask
    initial begin
        test_reset();
        test_back_to_back();
        test_stall();
        test_seq();
        test_checksum();
        test_cfg();
        test_reset_midrun();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
